// File: rtl/uni_shift_pkg.sv
// Shared definitions for the universal shift engine: operation encodings,
// burst FSM states and the test for which operations may run as a burst.
package uni_shift_pkg;

   localparam logic [2:0] MODE_HOLD = 3'b000;
   localparam logic [2:0] MODE_SL   = 3'b001;
   localparam logic [2:0] MODE_SR   = 3'b010;
   localparam logic [2:0] MODE_LOAD = 3'b011;
   localparam logic [2:0] MODE_ROL  = 3'b100;
   localparam logic [2:0] MODE_ROR  = 3'b101;
   localparam logic [2:0] MODE_ASR  = 3'b110;
   localparam logic [2:0] MODE_RSVD = 3'b111;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Only movement operations make sense repeated; HOLD, LOAD and the
   // reserved code are executed once even when start is raised.
   function automatic logic is_burst_mode(input logic [2:0] m);
      return (m == MODE_SL)  || (m == MODE_SR) || (m == MODE_ROL) ||
             (m == MODE_ROR) || (m == MODE_ASR);
   endfunction

endpackage

// File: rtl/uni_shift_next.sv
// Next-value mux for the shift register. Purely combinational so that the
// manual path and the burst path share a single copy of the datapath.
module uni_shift_next
   import uni_shift_pkg::*;
#(
   parameter int N = 8
) (
   input  logic [N-1:0] r,
   input  logic [2:0]   op,
   input  logic         s_in,
   input  logic [N-1:0] p_in,
   output logic [N-1:0] r_next
);

   // Select the register's next contents for the requested operation.
   always_comb begin
      r_next = r;
      case (op)
         MODE_SL:   r_next = {r[N-2:0], s_in};
         MODE_SR:   r_next = {s_in, r[N-1:1]};
         MODE_LOAD: r_next = p_in;
         MODE_ROL:  r_next = {r[N-2:0], r[N-1]};
         MODE_ROR:  r_next = {r[0], r[N-1:1]};
         MODE_ASR:  r_next = {r[N-1], r[N-1:1]};
         default:   r_next = r;
      endcase
   end

endmodule

// File: rtl/uni_shift_engine.sv
// Universal shift register with a burst engine: in IDLE it executes one
// operation per cycle, and a start pulse can hand control to the FSM which
// repeats a latched shift/rotate len times and then pulses done.
module uni_shift_engine
   import uni_shift_pkg::*;
#(
   parameter  int N     = 8,
   localparam int CNT_W = $clog2(N + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       mode,
   input  logic [N-1:0]     p_in,
   input  logic             s_in,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic [N-1:0]     p_out,
   output logic             s_out_lsb,
   output logic             s_out_msb,
   output logic             busy,
   output logic             done
);

   state_t           state;
   logic [N-1:0]     r;
   logic [N-1:0]     r_next;
   logic [2:0]       run_mode;
   logic [CNT_W-1:0] counter;
   logic [2:0]       active_op;
   logic             launch;

   // During a burst the latched operation drives the datapath and the live
   // mode input is ignored.
   assign active_op = (state == ST_RUN) ? run_mode : mode;

   // A burst launches only for a movement op with a non-zero length.
   assign launch = start && is_burst_mode(mode) && (len != '0);

   uni_shift_next #(.N(N)) u_next (
      .r      (r),
      .op     (active_op),
      .s_in   (s_in),
      .p_in   (p_in),
      .r_next (r_next)
   );

   // Burst FSM together with the shift register, counter and done pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         r        <= '0;
         run_mode <= MODE_HOLD;
         counter  <= '0;
         done     <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (launch) begin
                  run_mode <= mode;
                  counter  <= len;
                  state    <= ST_RUN;
                  done     <= 1'b0;
               end else begin
                  r    <= r_next;
                  done <= start;
               end
            end
            ST_RUN: begin
               r       <= r_next;
               counter <= counter - CNT_W'(1);
               if (counter == CNT_W'(1)) begin
                  state <= ST_IDLE;
                  done  <= 1'b1;
               end else begin
                  done  <= 1'b0;
               end
            end
            default: begin
               state <= ST_IDLE;
               done  <= 1'b0;
            end
         endcase
      end
   end

   assign busy      = (state == ST_RUN);
   assign p_out     = r;
   assign s_out_lsb = r[0];
   assign s_out_msb = r[N-1];

endmodule

// File: tb/tb_uni_shift_engine.sv
// Self-checking bench for uni_shift_engine (N=8): directed scenarios then
// randomized traffic, all compared against an arithmetic reference model.
module tb_uni_shift_engine;

   localparam int N = 8;
   localparam int CNT_W = 4;

   logic             clk;
   logic             reset;
   logic [2:0]       mode;
   logic [N-1:0]     p_in;
   logic             s_in;
   logic             start;
   logic [CNT_W-1:0] len;
   logic [N-1:0]     p_out;
   logic             s_out_lsb;
   logic             s_out_msb;
   logic             busy;
   logic             done;

   int tests;
   int fails;

   logic [7:0] m_r;
   int         m_left;
   logic       m_done;
   logic [2:0] m_run_mode;

   uni_shift_engine #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .mode      (mode),
      .p_in      (p_in),
      .s_in      (s_in),
      .start     (start),
      .len       (len),
      .p_out     (p_out),
      .s_out_lsb (s_out_lsb),
      .s_out_msb (s_out_msb),
      .busy      (busy),
      .done      (done)
   );

   // Free-running clock, period 10.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] refOp(input logic [2:0] m, input logic [7:0] r,
                                        input logic s, input logic [7:0] p);
      int v;
      int sv;
      v  = int'(r);
      sv = s ? 1 : 0;
      case (m)
         3'd1: return 8'((v * 2 + sv) % 256);
         3'd2: return 8'(v / 2 + sv * 128);
         3'd3: return p;
         3'd4: return 8'((v * 2) % 256 + v / 128);
         3'd5: return 8'(v / 2 + (v % 2) * 128);
         3'd6: return 8'(v / 2 + ((v >= 128) ? 128 : 0));
         default: return r;
      endcase
   endfunction

   function automatic logic isRepeatable(input logic [2:0] m);
      return (m == 3'd1) || (m == 3'd2) || (m == 3'd4) || (m == 3'd5) || (m == 3'd6);
   endfunction

   task automatic modelReset();
      m_r        = 8'h00;
      m_left     = 0;
      m_done     = 1'b0;
      m_run_mode = 3'd0;
   endtask

   task automatic modelStep(input logic [2:0] md, input logic [7:0] pin,
                            input logic sin, input logic st, input logic [3:0] ln);
      if (m_left > 0) begin
         m_r    = refOp(m_run_mode, m_r, sin, pin);
         m_left = m_left - 1;
         m_done = (m_left == 0);
      end else if (st && isRepeatable(md) && ln != 4'd0) begin
         m_run_mode = md;
         m_left     = int'(ln);
         m_done     = 1'b0;
      end else begin
         m_r    = refOp(md, m_r, sin, pin);
         m_done = st;
      end
   endtask

   task automatic checkOutput(input string tag, input logic [7:0] observed,
                              input logic [7:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, "_pout"}, p_out, m_r);
      checkOutput({tag, "_busy"}, {7'd0, busy}, {7'd0, (m_left > 0)});
      checkOutput({tag, "_done"}, {7'd0, done}, {7'd0, m_done});
      checkOutput({tag, "_lsb"}, {7'd0, s_out_lsb}, {7'd0, m_r[0]});
      checkOutput({tag, "_msb"}, {7'd0, s_out_msb}, {7'd0, m_r[7]});
   endtask

   task automatic applyStimulus(input logic [2:0] md, input logic [7:0] pin,
                                input logic sin, input logic st, input logic [3:0] ln,
                                input string tag);
      mode  = md;
      p_in  = pin;
      s_in  = sin;
      start = st;
      len   = ln;
      @(posedge clk);
      modelStep(md, pin, sin, st, ln);
      #1;
      checkAll(tag);
   endtask

   task automatic pulseReset(input string tag);
      #2;
      reset = 1'b1;
      #1;
      modelReset();
      checkAll({tag, "_async"});
      @(posedge clk);
      #1;
      checkAll({tag, "_held"});
      reset = 1'b0;
   endtask

   // Directed scenarios followed by randomized traffic.
   initial begin
      logic [7:0] lsbSeq;
      logic [7:0] sinSeq;
      int         doneCount;
      tests = 0;
      fails = 0;
      reset = 1'b1;
      mode  = 3'd0;
      p_in  = 8'h00;
      s_in  = 1'b0;
      start = 1'b0;
      len   = 4'd0;
      modelReset();
      #7;
      checkAll("reset_init");
      #4;
      reset = 1'b0;

      // Reset in the middle of manual activity.
      applyStimulus(3'd3, 8'h3C, 1'b0, 1'b0, 4'd0, "t1_load");
      applyStimulus(3'd1, 8'h00, 1'b1, 1'b0, 4'd0, "t1_sl");
      pulseReset("t1_rst");
      checkOutput("t1_pout_zero", p_out, 8'h00);

      // Single manual operations with known results.
      applyStimulus(3'd3, 8'hA5, 1'b0, 1'b0, 4'd0, "t2_load");
      applyStimulus(3'd1, 8'h00, 1'b1, 1'b0, 4'd0, "t2_sl");
      checkOutput("t2_sl_const", p_out, 8'h4B);
      applyStimulus(3'd3, 8'hA5, 1'b0, 1'b0, 4'd0, "t2_load2");
      applyStimulus(3'd5, 8'h00, 1'b0, 1'b0, 4'd0, "t2_ror");
      checkOutput("t2_ror_const", p_out, 8'hD2);
      applyStimulus(3'd3, 8'h80, 1'b0, 1'b0, 4'd0, "t2_load3");
      applyStimulus(3'd6, 8'h00, 1'b0, 1'b0, 4'd0, "t2_asr");
      checkOutput("t2_asr_const", p_out, 8'hC0);

      // SR burst serialising B4 LSB-first.
      lsbSeq = 8'hB4;
      applyStimulus(3'd3, 8'hB4, 1'b0, 1'b0, 4'd0, "t3_load");
      applyStimulus(3'd2, 8'h00, 1'b0, 1'b1, 4'd8, "t3_start");
      for (int k = 0; k < 8; k++) begin
         checkOutput("t3_busy_const", {7'd0, busy}, 8'h01);
         checkOutput("t3_lsb_const", {7'd0, s_out_lsb}, {7'd0, lsbSeq[k]});
         applyStimulus(3'd3, 8'hFF, 1'b0, (k == 3), 4'd5, "t3_run");
      end
      checkOutput("t3_pout_const", p_out, 8'h00);
      checkOutput("t3_done_const", {7'd0, done}, 8'h01);
      checkOutput("t3_busy_fall", {7'd0, busy}, 8'h00);

      // Zero-length and non-movement starts complete immediately.
      applyStimulus(3'd1, 8'h00, 1'b0, 1'b1, 4'd0, "t5_len0");
      checkOutput("t5_len0_pout", p_out, 8'h00);
      checkOutput("t5_len0_done", {7'd0, done}, 8'h01);
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t5_gap");
      applyStimulus(3'd3, 8'h5A, 1'b0, 1'b1, 4'd7, "t5_load");
      checkOutput("t5_load_pout", p_out, 8'h5A);
      checkOutput("t5_load_busy", {7'd0, busy}, 8'h00);
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t5_gap2");
      applyStimulus(3'd5, 8'h00, 1'b0, 1'b1, 4'd3, "t5_ror_start");
      applyStimulus(3'd1, 8'h00, 1'b1, 1'b1, 4'd15, "t5_ignored");
      applyStimulus(3'd1, 8'h00, 1'b1, 1'b1, 4'd15, "t5_ignored2");
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t5_ror_end");
      checkOutput("t5_ror_pout", p_out, 8'h4B);

      // SL burst deserialising a bit stream, with exactly one done pulse.
      sinSeq    = 8'b0110_0101;
      doneCount = 0;
      applyStimulus(3'd1, 8'h00, 1'b0, 1'b1, 4'd8, "t4_start");
      for (int k = 0; k < 8; k++) begin
         applyStimulus(3'd0, 8'h00, sinSeq[k], 1'b0, 4'd0, "t4_run");
         if (done) doneCount++;
      end
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t4_after");
      if (done) doneCount++;
      checkOutput("t4_pout_const", p_out, 8'hA6);
      checkOutput("t4_done_count", 8'(doneCount), 8'h01);

      // Reset abandons a burst; then a ROL longer than the register.
      applyStimulus(3'd3, 8'hB4, 1'b0, 1'b0, 4'd0, "t6_load");
      applyStimulus(3'd2, 8'h00, 1'b0, 1'b1, 4'd8, "t6_start");
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t6_run1");
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t6_run2");
      pulseReset("t6_rst");
      applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t6_nodone");
      checkOutput("t6_nodone_const", {7'd0, done}, 8'h00);
      applyStimulus(3'd3, 8'h81, 1'b0, 1'b0, 4'd0, "t6_load81");
      applyStimulus(3'd4, 8'h00, 1'b0, 1'b1, 4'd9, "t6_rol_start");
      for (int k = 0; k < 9; k++) begin
         applyStimulus(3'd0, 8'h00, 1'b0, 1'b0, 4'd0, "t6_rol_run");
      end
      checkOutput("t6_rol_const", p_out, 8'h03);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 300; k++) begin
         applyStimulus(3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)), "rand");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
